tlb_op_seq: RTL

- Sequences the TLB maintenance instructions TLBP, TLBR and TLBWI onto the shared TLB ports.
- Arbitrates the single TLB search port (s1) between data-side memory lookups and TLBP.
- Sits between the WB/CP0 logic, which issues operations and consumes results, and the TLB array.
- After every TLBWI it holds instruction fetch for a programmable number of cycles.

---
 rtl/tlb_pkg.sv | 45 ++++
 rtl/tlb_op_seq_if.sv | 71 +++++++
 rtl/tlb_search_arb.sv | 53 +++++
 rtl/tlb_op_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_op_seq shared types: op codes, TLB entry layout, FSM states.
// Optional TLBWI duplicate check is enabled by TLBWI_DUP_CHECK_EN.
package tlb_pkg;

  localparam int TLB_ENTRY_W = 78;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_TLBP  = 2'b01;
  localparam logic [1:0] OP_TLBR  = 2'b10;
  localparam logic [1:0] OP_TLBWI = 2'b11;

  localparam int E_V1   = 0;
  localparam int E_D1   = 1;
  localparam int E_C1   = 2;
  localparam int E_PFN1 = 5;
  localparam int E_V0   = 25;
  localparam int E_D0   = 26;
  localparam int E_C0   = 27;
  localparam int E_PFN0 = 30;
  localparam int E_G    = 50;
  localparam int E_ASID = 51;
  localparam int E_VPN2 = 59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_READ,
    ST_WRITE,
    ST_FLUSH,
    ST_RESP
`ifdef TLBWI_DUP_CHECK_EN
    , ST_CHK
`endif
  } state_e;

  // EntryLo keeps G in bit 0; the entry holds a single G = g0 & g1.
  function automatic logic [TLB_ENTRY_W-1:0] mk_entry(
    input logic [26:0] hi,
    input logic [25:0] lo0,
    input logic [25:0] lo1
  );
    return {hi, lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
  endfunction

endpackage

// File: rtl/tlb_op_seq_if.sv
// Bus bundle between WB/CP0, the TLB array and tlb_op_seq.
// slave = sequencer side, master = environment side.
interface tlb_op_seq_if #(
  parameter int IDX_W = 4
);
  import tlb_pkg::*;

  logic                   op_valid;
  logic                   op_ready;
  logic [1:0]             op_code;
  logic                   op_cancel;
  logic [26:0]            cp0_entryhi;
  logic [IDX_W-1:0]       cp0_index;
  logic [25:0]            cp0_entrylo0;
  logic [25:0]            cp0_entrylo1;
  logic                   mem_lk_valid;
  logic                   mem_lk_ready;
  logic [18:0]            mem_lk_vpn2;
  logic                   mem_lk_odd;
  logic [7:0]             mem_lk_asid;
  logic [18:0]            s1_vpn2;
  logic                   s1_odd;
  logic [7:0]             s1_asid;
  logic                   s1_found;
  logic [IDX_W-1:0]       s1_index;
  logic [IDX_W-1:0]       r_index;
  logic [TLB_ENTRY_W-1:0] r_entry;
  logic                   we;
  logic [IDX_W-1:0]       w_index;
  logic [TLB_ENTRY_W-1:0] w_entry;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [1:0]             resp_op;
  logic                   resp_found;
  logic [IDX_W-1:0]       resp_index;
  logic [TLB_ENTRY_W-1:0] resp_entry;
  logic                   fetch_hold;

  modport slave (
    input  op_valid, op_code, op_cancel,
    input  cp0_entryhi, cp0_index,
    input  cp0_entrylo0, cp0_entrylo1,
    input  mem_lk_valid, mem_lk_vpn2,
    input  mem_lk_odd, mem_lk_asid,
    input  s1_found, s1_index, r_entry,
    input  resp_ready,
    output op_ready, mem_lk_ready,
    output s1_vpn2, s1_odd, s1_asid,
    output r_index, we, w_index, w_entry,
    output resp_valid, resp_op, resp_found,
    output resp_index, resp_entry,
    output fetch_hold
  );

  modport master (
    output op_valid, op_code, op_cancel,
    output cp0_entryhi, cp0_index,
    output cp0_entrylo0, cp0_entrylo1,
    output mem_lk_valid, mem_lk_vpn2,
    output mem_lk_odd, mem_lk_asid,
    output s1_found, s1_index, r_entry,
    output resp_ready,
    input  op_ready, mem_lk_ready,
    input  s1_vpn2, s1_odd, s1_asid,
    input  r_index, we, w_index, w_entry,
    input  resp_valid, resp_op, resp_found,
    input  resp_index, resp_entry,
    input  fetch_hold
  );

endinterface

// File: rtl/tlb_search_arb.sv
// Search port mux: memory lookups win unless the op has
// already lost MAX_WAIT consecutive cycles.
module tlb_search_arb #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_req_i,
  input  logic [18:0] op_vpn2_i,
  input  logic [7:0]  op_asid_i,
  input  logic        mem_valid_i,
  input  logic [18:0] mem_vpn2_i,
  input  logic        mem_odd_i,
  input  logic [7:0]  mem_asid_i,
  output logic        op_gnt_o,
  output logic        mem_ready_o,
  output logic [18:0] s1_vpn2_o,
  output logic        s1_odd_o,
  output logic [7:0]  s1_asid_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          starved;

  assign starved     = (wait_q == CW'(MAX_WAIT));
  assign op_gnt_o    = op_req_i
                     && (!mem_valid_i || starved);
  assign mem_ready_o = !op_gnt_o;

  assign s1_vpn2_o = op_gnt_o ? op_vpn2_i : mem_vpn2_i;
  assign s1_odd_o  = op_gnt_o ? 1'b0      : mem_odd_i;
  assign s1_asid_o = op_gnt_o ? op_asid_i : mem_asid_i;

  always_comb begin
    wait_d = wait_q;
    if (!op_req_i || op_gnt_o) begin
      wait_d = '0;
    end else if (mem_valid_i && !starved) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/tlb_op_seq.sv
// Sequences TLBP/TLBR/TLBWI onto the TLB ports, holds fetch after TLBWI.
// TLBWI_DUP_CHECK_EN adds a duplicate-entry search before writing.
module tlb_op_seq
  import tlb_pkg::*;
#(
  parameter int TLBNUM       = 16,
  parameter int IDX_W        = $clog2(TLBNUM),
  parameter int MAX_WAIT     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           resetn,
  tlb_op_seq_if.slave   bus
);

  localparam int FW = (FLUSH_CYCLES > 1)
                    ? $clog2(FLUSH_CYCLES) : 1;

`ifdef TLBWI_DUP_CHECK_EN
  localparam state_e WI_FIRST = ST_CHK;
`else
  localparam state_e WI_FIRST = ST_WRITE;
`endif

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [26:0]            hi_q, hi_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [25:0]            lo0_q, lo0_d;
  logic [25:0]            lo1_q, lo1_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   found_q, found_d;
  logic [IDX_W-1:0]       rix_q, rix_d;
  logic [TLB_ENTRY_W-1:0] ent_q, ent_d;

  logic op_req;
  logic op_gnt;
  logic acc;

`ifdef TLBWI_DUP_CHECK_EN
  assign op_req = (state_q == ST_SRCH)
               || (state_q == ST_CHK);
`else
  assign op_req = (state_q == ST_SRCH);
`endif

  tlb_search_arb #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk         (clk),
    .resetn      (resetn),
    .op_req_i    (op_req),
    .op_vpn2_i   (hi_q[26:8]),
    .op_asid_i   (hi_q[7:0]),
    .mem_valid_i (bus.mem_lk_valid),
    .mem_vpn2_i  (bus.mem_lk_vpn2),
    .mem_odd_i   (bus.mem_lk_odd),
    .mem_asid_i  (bus.mem_lk_asid),
    .op_gnt_o    (op_gnt),
    .mem_ready_o (bus.mem_lk_ready),
    .s1_vpn2_o   (bus.s1_vpn2),
    .s1_odd_o    (bus.s1_odd),
    .s1_asid_o   (bus.s1_asid)
  );

  // resetn gates op_ready so nothing is accepted while in reset.
  assign bus.op_ready = resetn
                     && (state_q == ST_IDLE)
                     && !bus.op_cancel;
  assign acc = bus.op_valid && bus.op_ready;

  assign bus.r_index    = idx_q;
  assign bus.we         = (state_q == ST_WRITE);
  assign bus.w_index    = idx_q;
  assign bus.w_entry    = mk_entry(hi_q, lo0_q, lo1_q);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_op    = op_q;
  assign bus.resp_found = found_q;
  assign bus.resp_index = rix_q;
  assign bus.resp_entry = ent_q;
  assign bus.fetch_hold = (state_q == ST_WRITE)
                       || (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    lo0_d   = lo0_q;
    lo1_d   = lo1_q;
    fcnt_d  = fcnt_q;
    found_d = found_q;
    rix_d   = rix_q;
    ent_d   = ent_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          op_d    = bus.op_code;
          hi_d    = bus.cp0_entryhi;
          idx_d   = bus.cp0_index;
          lo0_d   = bus.cp0_entrylo0;
          lo1_d   = bus.cp0_entrylo1;
          found_d = 1'b0;
          rix_d   = '0;
          ent_d   = '0;
          unique case (1'b1)
            bus.op_code == OP_TLBP:  state_d = ST_SRCH;
            bus.op_code == OP_TLBR:  state_d = ST_READ;
            bus.op_code == OP_TLBWI: state_d = WI_FIRST;
            default:                 state_d = ST_IDLE;
          endcase
        end
      end
      ST_SRCH: begin
        if (bus.op_cancel) begin
          state_d = ST_IDLE;
        end else if (op_gnt) begin
          found_d = bus.s1_found;
          rix_d   = bus.s1_index;
          state_d = ST_RESP;
        end
      end
      ST_READ: begin
        if (bus.op_cancel) begin
          state_d = ST_IDLE;
        end else begin
          ent_d   = bus.r_entry;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        fcnt_d  = '0;
        state_d = (FLUSH_CYCLES == 0)
                ? ST_RESP : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (fcnt_q == FW'(FLUSH_CYCLES - 1)) begin
          fcnt_d  = '0;
          state_d = ST_RESP;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.op_cancel || bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef TLBWI_DUP_CHECK_EN
      ST_CHK: begin
        if (bus.op_cancel) begin
          state_d = ST_IDLE;
        end else if (op_gnt) begin
          if (bus.s1_found && bus.s1_index != idx_q) begin
            found_d = 1'b1;
            rix_d   = bus.s1_index;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      lo0_q   <= '0;
      lo1_q   <= '0;
      fcnt_q  <= '0;
      found_q <= 1'b0;
      rix_q   <= '0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      lo0_q   <= lo0_d;
      lo1_q   <= lo1_d;
      fcnt_q  <= fcnt_d;
      found_q <= found_d;
      rix_q   <= rix_d;
      ent_q   <= ent_d;
    end
  end

endmodule
